// File: rtl/mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// mux_nto1_reg
//
// N-to-1 multiplexer with a registered output. It has two operating modes:
//   - manual: the channel is chosen by the sel port.
//   - scan:   an internal index steps through every channel. It dwells DWELL
//             cycles on each channel and then advances.
//
// Parameters
//   WIDTH   bit width of each channel and of mux_out
//   NUM_CH  number of channels (2 .. 2**SEL_W)
//   SEL_W   width of sel / cur_sel
//   DWELL   cycles spent on each channel in scan mode (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low holds mux_out/cur_sel and scan position
//   mode       0 = manual select, 1 = auto scan (ignored while en = 0)
//   sel        manual channel select (ignored in scan mode)
//   in_bus     packed channels, channel k at [k*WIDTH +: WIDTH]
//   mux_out    registered selected data
//   cur_sel    channel index that produced the current mux_out
//   out_valid  mux_out holds a valid sample taken on the previous edge
//   wrap       one-cycle pulse on the first sample of channel 0 after the
//              scan index wrapped from NUM_CH-1
//
// Output qualification: this is a source-only interface with no ready input.
// The consumer may use mux_out in any cycle in which out_valid is 1. out_valid
// is 0 after reset, while disabled, and after an out-of-range manual select.
// Every output is taken straight from flops, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module mux_nto1_reg #(
  parameter int WIDTH  = 1,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]        mux_out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    out_valid,
  output logic                    wrap
);

  // A dwell counter of at least one bit keeps DWELL = 1 legal. In that case
  // the counter stays at 0 and the index advances on every scan edge.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // state_q records the operation performed on the most recent edge.
  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   data_q,      data_d;
  logic [SEL_W-1:0]   cur_q,       cur_d;
  logic               sel_ok_q,    sel_ok_d;
  logic               wrap_q,      wrap_d;
  logic               wrap_pend_q, wrap_pend_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [SEL_W-1:0]   idx_q,       idx_d;

  // Channel pick. The loop compares against every legal channel number, so an
  // out-of-range index returns zero and no part-select runs past the bus.
  function automatic logic [WIDTH-1:0] pick_ch(
    input logic [SEL_W-1:0]        ch,
    input logic [NUM_CH*WIDTH-1:0] bus
  );
    logic [WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) res = bus[k*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  function automatic logic ch_in_range(input logic [SEL_W-1:0] ch);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) ok = 1'b1;
    end
    return ok;
  endfunction

  logic             man_ok;
  logic [WIDTH-1:0] man_data;
  logic [WIDTH-1:0] scan_data;

  always_comb begin
    man_ok    = ch_in_range(sel);
    man_data  = pick_ch(sel, in_bus);
    scan_data = pick_ch(idx_q, in_bus);
  end

  always_comb begin
    data_d      = data_q;
    cur_d       = cur_q;
    sel_ok_d    = sel_ok_q;
    wrap_d      = 1'b0;
    wrap_pend_d = wrap_pend_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;

    // en overrides mode.
    if (!en)       state_d = ST_IDLE;
    else if (mode) state_d = ST_SCAN;
    else           state_d = ST_MANUAL;

    case (state_d)
      ST_MANUAL: begin
        cur_d       = sel;
        sel_ok_d    = man_ok;
        data_d      = man_ok ? man_data : '0;
        // Any later scan starts at channel 0 with a fresh dwell. It must not
        // inherit a wrap that was pending from an earlier scan.
        cnt_d       = '0;
        idx_d       = '0;
        wrap_pend_d = 1'b0;
      end

      ST_SCAN: begin
        data_d      = scan_data;
        cur_d       = idx_q;
        sel_ok_d    = 1'b1;
        // wrap marks the first sample of channel 0 after a wrap. The pending
        // flag carries the event across any idle cycles in between.
        wrap_d      = wrap_pend_q;
        wrap_pend_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            wrap_pend_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // Idle: data, channel and scan position hold. wrap defaults to 0.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cur_q       <= '0;
      sel_ok_q    <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cur_q       <= cur_d;
      sel_ok_q    <= sel_ok_d;
      wrap_q      <= wrap_d;
      wrap_pend_q <= wrap_pend_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign mux_out   = data_q;
  assign cur_sel   = cur_q;
  assign wrap      = wrap_q;
  // Decoded from flops only. A scan sample is always valid. A manual sample
  // is valid only when its select was in range.
  assign out_valid = (state_q == ST_SCAN) || ((state_q == ST_MANUAL) && sel_ok_q);

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised N-to-1 multiplexer with a registered output. It is the successor to the combinational 2-to-1 mux.
- Two operating modes:
  - manual: the channel comes from the sel port.
  - scan: an internal counter steps through every channel, dwelling a programmable number of cycles on each.
- Sits between grouped input sources and a single downstream consumer. Provides a valid flag and a scan-wrap strobe.

Parameters:
- WIDTH, 1, bit width of each input channel and of mux_out
- NUM_CH, 4, number of input channels (2..2**SEL_W)
- SEL_W, 2, width of sel and cur_sel; must satisfy 2**SEL_W >= NUM_CH
- DWELL, 4, cycles spent on each channel in scan mode (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low = hold
- mode  input  1  0 = manual select, 1 = auto scan
- sel  input  SEL_W  manual channel select
- in_bus  input  NUM_CH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- mux_out  output  WIDTH  registered selected data
- cur_sel  output  SEL_W  channel index that produced the current mux_out
- out_valid  output  1  mux_out holds a valid sample taken on the previous edge
- wrap  output  1  one-cycle pulse when the scan index wraps from NUM_CH-1 to 0

Behaviour:
- Reset (rst_n low, async, any time, including mid-scan):
  - mux_out=0, cur_sel=0, out_valid=0, wrap=0.
  - Dwell counter=0, scan index=0, state=IDLE.
  - On deassertion, the first update occurs on the first rising edge with en=1.
- States and transitions, evaluated each edge:
  - IDLE: en=0. Next state is IDLE, MANUAL or SCAN per en/mode.
  - MANUAL: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - en=0 overrides mode.
- IDLE:
  - mux_out and cur_sel hold.
  - out_valid=0, wrap=0.
  - Dwell counter and scan index hold.
- MANUAL:
  - Latency is 1 cycle: at the edge, mux_out <= channel[sel], cur_sel <= sel, out_valid <= 1.
  - sel >= NUM_CH (out of range): mux_out <= 0, cur_sel <= sel, out_valid <= 0.
  - wrap=0.
  - Dwell counter and scan index are cleared to 0.
- SCAN:
  - Each edge samples mux_out <= channel[scan index]; cur_sel <= scan index; out_valid <= 1. Data is re-sampled every cycle, so live input changes are tracked.
  - Dwell counter increments each cycle. When it reaches DWELL-1, it clears to 0 and the scan index advances.
  - Scan index at NUM_CH-1 advances to 0 instead. wrap is 1 for the one cycle in which cur_sel first shows 0 after NUM_CH-1.
  - Entering SCAN from MANUAL or IDLE-after-MANUAL starts at channel 0 with the dwell counter at 0. No wrap pulse on entry.
  - SCAN to IDLE to SCAN resumes the held index and counter.
  - DWELL=1: the index advances every cycle.
- Mode change SCAN to MANUAL: the next edge uses sel, with no extra latency.
- sel is ignored in SCAN; in_bus is sampled only at edges.
- No combinational path from any input to any output.

Test Plan:
- Reset/manual: WIDTH=8, NUM_CH=4.
  - Stimulus: in_bus={8'hD4,8'hC3,8'hB2,8'hA1}; rst_n low then high; en=1, mode=0; sel=2 for one cycle.
  - Required: after reset all outputs are 0; one edge later mux_out=8'hC3, cur_sel=2, out_valid=1.
  - Then sel=0, 1, 3 on successive cycles: mux_out=A1, B2, D4 on successive edges.
- Out of range:
  - Stimulus: NUM_CH=3, SEL_W=2, sel=3.
  - Required: mux_out=0, out_valid=0, cur_sel=3.
  - Then sel=1: next edge gives channel 1 with out_valid=1.
- Scan/wrap:
  - Stimulus: NUM_CH=4, DWELL=2, mode=1 from manual.
  - Required: cur_sel sequence 0,0,1,1,2,2,3,3,0,0. wrap=1 only on the first cycle of the second 0. mux_out matches each channel.
- Hold:
  - Stimulus: mid-scan at cur_sel=2 after 1 dwell cycle, drop en for 5 cycles.
  - Required: mux_out and cur_sel frozen, out_valid=0.
  - Then re-raise en: one more cycle on channel 2, then channel 3.
- Async reset mid-scan:
  - Stimulus: assert rst_n low between edges while cur_sel=3.
  - Required: outputs go to 0 immediately, without waiting for a clock edge. After release the scan restarts at channel 0 with no wrap pulse.
- Exhaustive manual:
  - Stimulus: WIDTH=1, NUM_CH=2; loop {sel,in1,in0} over 0..7.
  - Required: mux_out equals the 2:1 truth table, delayed one cycle.
